scancode_display_scheduler: RTL and testbench
=============================================

Name: scancode_display_scheduler

Overview:
- Controller between the PS/2 serial receiver's byte output and the 4-digit multiplexed seven-segment display.
- Parses the scancode byte stream (E0/F0 prefixes) and keeps a 4-entry history of make codes, newest first.
- Time-multiplexes the history onto the shared scancode-to-7-segment decoder and the active-low digit enables.
- Replaces the fixed single-digit enable with a scanned, 4-digit view.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays active. Legal range 2..2^20.
- HIST_DEPTH, 4: history entries. Fixed to 4 (one per digit); other values are illegal.

Ports:
- clock  input  1  system clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- code_in  input  8  received scancode byte.
- code_valid  input  1  one-cycle strobe; code_in is valid in the same cycle.
- cur_code  output  8  history byte for the active digit; drives the segment decoder.
- control  output  4  digit enables, active-low, one-cold.
- digit_sel  output  2  index of the active digit.
- key_count  output  8  saturating count of accepted make codes.

Behaviour:
- Reset (reset=0, asynchronous):
  - hist[0..3]=8'h00, slot_valid[3:0]=0.
  - digit_sel=0, control=4'b1110, cur_code=8'h00, key_count=0.
  - Refresh counter=0, held=0, parser FSM=IDLE.
- Parser FSM advances only on cycles with code_valid=1:
  - IDLE: E0->EXT; F0->BRK; any other byte is a make code (see push rule), stay IDLE.
  - EXT: F0->EXT_BRK; E0 stays EXT; any other byte is a make code, ->IDLE.
  - BRK: any byte is discarded, held<=0, ->IDLE.
  - EXT_BRK: any byte is discarded, held<=0, ->IDLE.
- Push rule for a make code C:
  - If held=1 and C==hist[0], it is a typematic repeat: ignored, no state change.
  - Otherwise shift: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=C.
  - Shift slot_valid the same way with slot_valid[0]<=1.
  - Set held<=1; key_count<=key_count+1, saturating at 8'hFF.
- Prefix bytes E0/F0 are never pushed.
- Refresh counter counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and digit_sel increments mod 4 (3->0).
- Outputs are combinational from registers:
  - control = ~(4'b0001 << digit_sel).
  - cur_code = hist[digit_sel].
- Latency: a push is visible on cur_code the cycle after its code_valid; a digit change appears on control/cur_code the cycle after terminal count.
- A push and a refresh tick in the same cycle both take effect; neither is dropped or delayed.
- code_valid held high on consecutive cycles: each cycle is a separate byte.
- Reset asserted mid-sequence (e.g. in BRK) aborts it; the next byte is parsed from IDLE.

Optional Feature:
- Macro: SCANCODE_BLANK_EMPTY_EN.
- Defined: when slot_valid[digit_sel]=0, control=4'b1111 (all digits off) and cur_code=8'h00 for that digit period. Scanning timing is unchanged.
- Undefined: empty slots are displayed normally as 8'h00 with their digit enabled.

Test Plan (REFRESH_DIV=4):
- Reset release, no input -> control=1110, cur_code=00, digit_sel 0->1->2->3->0 every 4 cycles, control 1110->1101->1011->0111->1110.
- Bytes 1C, F0, 1C, 32 -> hist={32,1C,00,00}, key_count=2; cur_code=32 while digit_sel=0.
- Bytes 1C,1C,1C (no break) -> one push, key_count=1; then F0,1C,1C -> second push, key_count=2, hist[0..1]={1C,1C}.
- Bytes E0, 75, E0, F0, 75 -> hist[0]=75, key_count=1, FSM back in IDLE, held=0; E0/F0 never pushed.
- Five makes 15,1D,24,2D,2C with breaks between -> hist={2C,2D,24,1D} (15 shifted out); 300 accepted makes -> key_count=FF.
- SCANCODE_BLANK_EMPTY_EN defined, one make 1C -> control=1110 with cur_code=1C for digit 0, control=1111 for digits 1-3. Undefined -> control one-cold for all 4 digits, cur_code=00 for digits 1-3.

Source files
------------

// File: rtl/scancode_display_scheduler_if.sv
// Bus between the PS/2 byte receiver and the display scheduler, together
// with the scheduler's view back to the seven-segment driver.
// master: byte source side (testbench / receiver glue).
// slave : scheduler side.
interface scancode_display_scheduler_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic [7:0] cur_code;
    logic [3:0] control;
    logic [1:0] digit_sel;
    logic [7:0] key_count;

    modport master (
        output code_in,
        output code_valid,
        input  cur_code,
        input  control,
        input  digit_sel,
        input  key_count
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output cur_code,
        output control,
        output digit_sel,
        output key_count
    );
endinterface

// File: rtl/scancode_display_scheduler.sv
// Scancode display scheduler.
// Parses the PS/2 scancode stream (E0 extended prefix, F0 break prefix),
// keeps the last four make codes newest-first, and scans them across a
// 4-digit multiplexed seven-segment display with active-low digit enables.
// Optional build macro: SCANCODE_BLANK_EMPTY_EN -- when defined, digits whose
// history slot has never been filled are blanked (all enables off, code 00).
// HIST_DEPTH is fixed at 4, one entry per digit.
module scancode_display_scheduler #(
    parameter int REFRESH_DIV = 50000,
    parameter int HIST_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    scancode_display_scheduler_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             hist_q [HIST_DEPTH];
    logic [HIST_DEPTH-1:0]  slot_valid_q;
    logic                   held_q;
    logic [7:0]             key_count_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [1:0]             digit_sel_q;

    logic                   is_make;
    logic                   is_drop;
    logic                   accept;
    logic                   tick;

    // Counter that stops at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Parser state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Parser next state; classifies each byte as make, discarded break target, or prefix.
    always_comb begin
        state_d = state_q;
        is_make = 1'b0;
        is_drop = 1'b0;
        if (bus.code_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.code_in == CODE_EXT) begin
                        state_d = EXT;
                    end else if (bus.code_in == CODE_BRK) begin
                        state_d = BRK;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                EXT: begin
                    if (bus.code_in == CODE_BRK) begin
                        state_d = EXT_BRK;
                    end else if (bus.code_in == CODE_EXT) begin
                        state_d = EXT;
                    end else begin
                        is_make = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    is_drop = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A make code repeating the newest entry while the key is still held is typematic.
    assign accept = is_make && !(held_q && (bus.code_in == hist_q[0]));

    // History shift register, slot occupancy, held flag and accepted-key count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= 8'h00;
            end
            slot_valid_q <= '0;
            held_q       <= 1'b0;
            key_count_q  <= 8'h00;
        end else begin
            if (accept) begin
                for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                    hist_q[i] <= hist_q[i-1];
                end
                hist_q[0]    <= bus.code_in;
                slot_valid_q <= {slot_valid_q[HIST_DEPTH-2:0], 1'b1};
                held_q       <= 1'b1;
                key_count_q  <= sat_inc8(key_count_q);
            end else if (is_drop) begin
                held_q <= 1'b0;
            end
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    // Refresh divider and active-digit index; independent of the parser path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            digit_sel_q <= 2'd0;
        end else if (tick) begin
            cnt_q       <= '0;
            digit_sel_q <= digit_sel_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Display outputs decoded from the active digit and its history slot.
    always_comb begin
        bus.control  = ~(4'b0001 << digit_sel_q);
        bus.cur_code = hist_q[digit_sel_q];
`ifdef SCANCODE_BLANK_EMPTY_EN
        if (!slot_valid_q[digit_sel_q]) begin
            bus.control  = 4'b1111;
            bus.cur_code = 8'h00;
        end
`endif
    end

    assign bus.digit_sel = digit_sel_q;
    assign bus.key_count = key_count_q;

endmodule

// File: tb/tb_scancode_display_scheduler.sv
// Directed testbench for scancode_display_scheduler with REFRESH_DIV=4.
// Expected values are hand-derived from the scancode parsing and scan rules.
module tb_scancode_display_scheduler;

    localparam int RDIV = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    scancode_display_scheduler_if bus_if ();

    scancode_display_scheduler #(
        .REFRESH_DIV (RDIV),
        .HIST_DEPTH  (4)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one rising edge; called and returns at a negedge.
    task automatic send_byte(input logic [7:0] b);
        bus_if.code_in    = b;
        bus_if.code_valid = 1'b1;
        @(negedge clk);
        bus_if.code_valid = 1'b0;
    endtask

    // Assert reset asynchronously, release on a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.code_valid = 1'b0;
        bus_if.code_in    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for digit i to become active, then check its code and enables.
    task automatic chk_slot(input string tag, input int i, input logic [7:0] code, input logic vld);
        int   waited;
        logic [3:0] exp_ctl;
        logic [7:0] exp_code;
        waited = 0;
        while (bus_if.digit_sel !== 2'(i) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            chk({tag, "_timeout"}, 32'(bus_if.digit_sel), 32'(i));
        end else begin
            exp_ctl  = ~(4'b0001 << i);
            exp_code = code;
`ifdef SCANCODE_BLANK_EMPTY_EN
            if (!vld) begin
                exp_ctl  = 4'b1111;
                exp_code = 8'h00;
            end
`else
            if (!vld) exp_code = 8'h00;
`endif
            chk({tag, "_code"}, 32'(bus_if.cur_code), 32'(exp_code));
            chk({tag, "_ctl"},  32'(bus_if.control),  32'(exp_ctl));
        end
    endtask

    initial begin
        logic [3:0] exp_ctl;
        int         exp_ds;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.code_in    = 8'h00;
        bus_if.code_valid = 1'b0;

        // Reset state, observed while reset is still asserted.
        #12;
        chk("rst_ds",   32'(bus_if.digit_sel), 32'd0);
        chk("rst_kc",   32'(bus_if.key_count), 32'd0);
        chk("rst_code", 32'(bus_if.cur_code),  32'h00);
`ifdef SCANCODE_BLANK_EMPTY_EN
        chk("rst_ctl",  32'(bus_if.control),   32'hF);
`else
        chk("rst_ctl",  32'(bus_if.control),   32'hE);
`endif

        // Scan timing with no input: digit advances every RDIV cycles.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_ds  = (k / RDIV) % 4;
            exp_ctl = ~(4'b0001 << exp_ds);
            chk($sformatf("scan_ds_%0d", k), 32'(bus_if.digit_sel), 32'(exp_ds));
`ifndef SCANCODE_BLANK_EMPTY_EN
            chk($sformatf("scan_ctl_%0d", k), 32'(bus_if.control), 32'(exp_ctl));
`endif
        end

        // Make, break, make: 1C F0 1C 32.
        do_reset();
        send_byte(8'h1C);
        chk("t2_lat_code", 32'(bus_if.cur_code), 32'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h32);
        chk("t2_kc", 32'(bus_if.key_count), 32'd2);
        chk_slot("t2_s0", 0, 8'h32, 1'b1);
        chk_slot("t2_s1", 1, 8'h1C, 1'b1);
        chk_slot("t2_s2", 2, 8'h00, 1'b0);
        chk_slot("t2_s3", 3, 8'h00, 1'b0);

        // Typematic repeat suppression, then release and re-press.
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        chk("t3_kc1", 32'(bus_if.key_count), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        chk("t3_kc2", 32'(bus_if.key_count), 32'd2);
        chk_slot("t3_s0", 0, 8'h1C, 1'b1);
        chk_slot("t3_s1", 1, 8'h1C, 1'b1);
        chk_slot("t3_s2", 2, 8'h00, 1'b0);

        // Extended make and extended break; the next 75 must be a fresh press.
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("t4_kc1", 32'(bus_if.key_count), 32'd1);
        chk_slot("t4_s0", 0, 8'h75, 1'b1);
        chk_slot("t4_s1", 1, 8'h00, 1'b0);
        send_byte(8'h75);
        chk("t4_kc2", 32'(bus_if.key_count), 32'd2);
        chk_slot("t4_s1b", 1, 8'h75, 1'b1);

        // Five makes with breaks: oldest shifts out.
        do_reset();
        send_byte(8'h15); send_byte(8'hF0); send_byte(8'h15);
        send_byte(8'h1D); send_byte(8'hF0); send_byte(8'h1D);
        send_byte(8'h24); send_byte(8'hF0); send_byte(8'h24);
        send_byte(8'h2D); send_byte(8'hF0); send_byte(8'h2D);
        send_byte(8'h2C);
        chk("t5_kc", 32'(bus_if.key_count), 32'd5);
        chk_slot("t5_s0", 0, 8'h2C, 1'b1);
        chk_slot("t5_s1", 1, 8'h2D, 1'b1);
        chk_slot("t5_s2", 2, 8'h24, 1'b1);
        chk_slot("t5_s3", 3, 8'h1D, 1'b1);

        // Saturation: alternating codes on back-to-back cycles are all accepted.
        for (int n = 0; n < 245; n++) begin
            send_byte((n % 2 == 0) ? 8'h10 : 8'h11);
        end
        chk("t5_kc250", 32'(bus_if.key_count), 32'hFA);
        for (int n = 0; n < 50; n++) begin
            send_byte((n % 2 == 0) ? 8'h10 : 8'h11);
        end
        chk("t5_kcsat", 32'(bus_if.key_count), 32'hFF);
        chk_slot("t5_s0sat", 0, 8'h11, 1'b1);
        chk_slot("t5_s1sat", 1, 8'h10, 1'b1);

        // Reset in BRK aborts the break; push coincides with a refresh tick.
        do_reset();
        send_byte(8'hF0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (RDIV - 1) @(negedge clk);
        chk("t6_ds_pre", 32'(bus_if.digit_sel), 32'd0);
        send_byte(8'h1C);
        chk("t6_ds_post", 32'(bus_if.digit_sel), 32'd1);
        chk("t6_kc", 32'(bus_if.key_count), 32'd1);
        chk_slot("t6_s0", 0, 8'h1C, 1'b1);
        chk_slot("t6_s1", 1, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
